// File: rtl/tia_hsync_decoder.sv
// TIA horizontal timing decoder: step counter, shadow LFSR, f3-style strobes and latches.
// Optional late HBLANK on HMOVE lines: define TIA_HSYNC_LATE_HBLANK_EN.
module tia_hsync_decoder #(
  parameter int STEPS     = 57,
  parameter int SHS_STEP  = 4,
  parameter int RHS_STEP  = 8,
  parameter int RCB_STEP  = 12,
  parameter int RHB_STEP  = 16,
  parameter int LRHB_STEP = 18,
  parameter int CNT_STEP  = 36
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  input  logic       rsync,
  input  logic       hmove_latch,
  output logic [5:0] count,
  output logic [5:0] poly,
  output logic       shb_n,
  output logic       rhb_n,
  output logic       shs_n,
  output logic       rhs_n,
  output logic       rcb_n,
  output logic       center,
  output logic       hsync,
  output logic       hblank
);

  logic       load;
  logic [5:0] nxt;
  logic       ent_shb;
  logic       ent_shs;
  logic       ent_rhs;
  logic       ent_rcb;
  logic       ent_rhb;
  logic       ent_lrhb;
  logic       ent_cnt;
  logic       rhb_hit;

  always_comb begin
    load = rsync | advance;
    nxt  = count;
    if (rsync)
      nxt = '0;
    else if (advance)
      nxt = (count == 6'(STEPS - 1)) ? '0 : count + 6'd1;
  end

  // An entry is any load, including rsync while already at 0.
  assign ent_shb  = load && (nxt == 6'd0);
  assign ent_shs  = load && (nxt == 6'(SHS_STEP));
  assign ent_rhs  = load && (nxt == 6'(RHS_STEP));
  assign ent_rcb  = load && (nxt == 6'(RCB_STEP));
  assign ent_rhb  = load && (nxt == 6'(RHB_STEP));
  assign ent_lrhb = load && (nxt == 6'(LRHB_STEP));
  assign ent_cnt  = load && (nxt == 6'(CNT_STEP));

`ifdef TIA_HSYNC_LATE_HBLANK_EN
  logic late;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      late <= 1'b0;
    else if (ent_rhb)
      late <= hmove_latch;
  end

  assign rhb_hit = (ent_rhb && !hmove_latch) || (ent_lrhb && late);
`else
  logic unused_late;

  assign unused_late = hmove_latch | ent_lrhb;
  assign rhb_hit     = ent_rhb;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      poly  <= '0;
    end else if (load) begin
      count <= nxt;
      poly  <= (nxt == 6'd0) ? 6'd0 : {poly[4:0], ~(poly[5] ^ poly[4])};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shb_n  <= 1'b1;
      rhb_n  <= 1'b1;
      shs_n  <= 1'b1;
      rhs_n  <= 1'b1;
      rcb_n  <= 1'b1;
      center <= 1'b0;
    end else begin
      shb_n  <= !ent_shb;
      rhb_n  <= !rhb_hit;
      shs_n  <= !ent_shs;
      rhs_n  <= !ent_rhs;
      rcb_n  <= !ent_rcb;
      center <= ent_cnt;
    end
  end

  // Reset side wins if both strobes are low together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync  <= 1'b0;
      hblank <= 1'b1;
    end else begin
      if (!rhs_n)
        hsync <= 1'b0;
      else if (!shs_n)
        hsync <= 1'b1;
      if (!rhb_n)
        hblank <= 1'b0;
      else if (!shb_n)
        hblank <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tia_hsync_decoder.sv
// Directed bench for tia_hsync_decoder; strobe vector order is {shb,rhb,shs,rhs,rcb}.
module tb_tia_hsync_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       advance;
  logic       rsync;
  logic       hmove_latch;
  logic [5:0] count;
  logic [5:0] poly;
  logic       shb_n;
  logic       rhb_n;
  logic       shs_n;
  logic       rhs_n;
  logic       rcb_n;
  logic       center;
  logic       hsync;
  logic       hblank;

  int checks   = 0;
  int failures = 0;

  tia_hsync_decoder dut (
    .clock(clock),
    .reset(reset),
    .advance(advance),
    .rsync(rsync),
    .hmove_latch(hmove_latch),
    .count(count),
    .poly(poly),
    .shb_n(shb_n),
    .rhb_n(rhb_n),
    .shs_n(shs_n),
    .rhs_n(rhs_n),
    .rcb_n(rcb_n),
    .center(center),
    .hsync(hsync),
    .hblank(hblank)
  );

  always #5 clock = ~clock;

  logic [4:0] strb;
  assign strb = {shb_n, rhb_n, shs_n, rhs_n, rcb_n};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(negedge clock);
    advance = 1'b1;
    @(posedge clock);
    #1;
    advance = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic adv_n(input int k);
    repeat (k) begin
      adv();
      wait_clk(3);
    end
  endtask

  initial begin
    reset       = 1'b1;
    advance     = 1'b0;
    rsync       = 1'b0;
    hmove_latch = 1'b0;
    wait_clk(3);
    check("rst_count", 32'(count), 0);
    check("rst_poly", 32'(poly), 0);
    check("rst_strb", 32'(strb), 32'h1f);
    check("rst_center", 32'(center), 0);
    check("rst_hsync", 32'(hsync), 0);
    check("rst_hblank", 32'(hblank), 1);
    @(negedge clock);
    reset = 1'b0;

    adv();
    check("s1_count", 32'(count), 1);
    check("s1_poly", 32'(poly), 32'h01);
    check("s1_strb", 32'(strb), 32'h1f);
    wait_clk(3);
    adv_n(2);

    adv();
    check("s4_count", 32'(count), 4);
    check("s4_poly", 32'(poly), 32'h0f);
    check("s4_strb", 32'(strb), 32'h1b);
    check("s4_hsync", 32'(hsync), 0);
    wait_clk(1);
    check("s4_strb_end", 32'(strb), 32'h1f);
    check("s4_hsync_set", 32'(hsync), 1);
    wait_clk(2);
    adv_n(1);
    check("s5_poly", 32'(poly), 32'h1f);
    adv();
    check("s6_poly", 32'(poly), 32'h3e);
    wait_clk(3);
    adv_n(1);

    adv();
    check("s8_strb", 32'(strb), 32'h1d);
    wait_clk(1);
    check("s8_hsync_clr", 32'(hsync), 0);
    wait_clk(2);
    adv_n(3);

    adv();
    check("s12_strb", 32'(strb), 32'h1e);
    wait_clk(3);
    adv_n(3);

    adv();
    check("s16_strb", 32'(strb), 32'h17);
    wait_clk(1);
    check("s16_hblank", 32'(hblank), 0);
    wait_clk(2);
    adv_n(19);

    adv();
    check("s36_center", 32'(center), 1);
    check("s36_count", 32'(count), 36);
    wait_clk(1);
    check("s36_center_end", 32'(center), 0);
    wait_clk(2);
    adv_n(20);
    check("s56_count", 32'(count), 56);

    adv();
    check("wrap_count", 32'(count), 0);
    check("wrap_poly", 32'(poly), 0);
    check("wrap_strb", 32'(strb), 32'h0f);
    wait_clk(1);
    check("wrap_hblank", 32'(hblank), 1);
    wait_clk(2);
    adv_n(15);

    hmove_latch = 1'b1;
    adv();
`ifdef TIA_HSYNC_LATE_HBLANK_EN
    check("late16_strb", 32'(strb), 32'h1f);
    wait_clk(1);
    check("late16_hblank", 32'(hblank), 1);
`else
    check("late16_strb", 32'(strb), 32'h17);
    wait_clk(1);
    check("late16_hblank", 32'(hblank), 0);
`endif
    wait_clk(2);
    hmove_latch = 1'b0;
    adv();
    check("late17_strb", 32'(strb), 32'h1f);
    wait_clk(3);
    adv();
    check("late18_count", 32'(count), 18);
`ifdef TIA_HSYNC_LATE_HBLANK_EN
    check("late18_strb", 32'(strb), 32'h17);
`else
    check("late18_strb", 32'(strb), 32'h1f);
`endif
    wait_clk(1);
    check("late18_hblank", 32'(hblank), 0);
    wait_clk(2);
    adv_n(12);
    check("s30_count", 32'(count), 30);

    @(negedge clock);
    rsync   = 1'b1;
    advance = 1'b1;
    @(posedge clock);
    #1;
    rsync   = 1'b0;
    advance = 1'b0;
    check("rsync_count", 32'(count), 0);
    check("rsync_poly", 32'(poly), 0);
    check("rsync_strb", 32'(strb), 32'h0f);
    wait_clk(1);
    check("rsync_strb_end", 32'(strb), 32'h1f);
    check("rsync_hblank", 32'(hblank), 1);
    wait_clk(2);
    adv();
    check("rsync_next", 32'(count), 1);
    wait_clk(3);
    adv_n(2);

    adv();
    check("mid_shs", 32'(strb), 32'h1b);
    #1;
    reset = 1'b1;
    #1;
    check("mid_count", 32'(count), 0);
    check("mid_strb", 32'(strb), 32'h1f);
    check("mid_hsync", 32'(hsync), 0);
    wait_clk(1);
    check("mid_hsync_hold", 32'(hsync), 0);
    @(negedge clock);
    reset = 1'b0;
    adv();
    check("post_count", 32'(count), 1);
    check("post_strb", 32'(strb), 32'h1f);
    wait_clk(1);
    check("post_hblank", 32'(hblank), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
